// File: rtl/pll_acq_ctrl.sv
// pll_acq_ctrl
//   Acquisition/lock sequencer for the PFD + loop filter PLL loop. It holds the
//   loop filter in reset (FLUSH), releases it and counts quiet PFD cycles to
//   declare lock (ACQ), and watches for sustained PFD activity to detect loss
//   of lock (LOCK). Acquisition attempts that stall are timed out and retried
//   a bounded number of times before the block parks in FAIL.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active high
//   enable       1 = run acquisition, 0 = return to IDLE
//   up, dn       PFD outputs
//   lf_rst       loop filter reset
//   gain_coarse  1 = coarse (acquisition) gain, 0 = fine (tracking) gain
//   locked       loop locked
//   lock_lost    one-cycle pulse on loss of lock
//   acq_tmo      one-cycle pulse on acquisition timeout
//   fail         retries exhausted, held until enable=0 or rst
//   state        0 IDLE, 1 FLUSH, 2 ACQ, 3 LOCK, 4 FAIL
module pll_acq_ctrl #(
    parameter int FLUSH_CYC  = 4,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int ACQ_TMO    = 1024,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       up,
    input  logic       dn,
    output logic       lf_rst,
    output logic       gain_coarse,
    output logic       locked,
    output logic       lock_lost,
    output logic       acq_tmo,
    output logic       fail,
    output logic [2:0] state
);

    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam int QW = $clog2(LOCK_CNT + 1);
    localparam int AW = $clog2(UNLOCK_CNT + 1);
    localparam int TW = $clog2(ACQ_TMO + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
    localparam logic [QW-1:0] LOCK_TH    = QW'(LOCK_CNT);
    localparam logic [AW-1:0] UNLOCK_TH  = AW'(UNLOCK_CNT);
    localparam logic [TW-1:0] TMO_TH     = TW'(ACQ_TMO);
    localparam logic [RW-1:0] RETRY_TH   = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_ACQ   = 3'd2,
        S_LOCK  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t        cur_st, nxt_st;
    logic [FW-1:0] flush_cnt, flush_n;
    logic [QW-1:0] quiet_cnt, quiet_n;
    logic [AW-1:0] act_cnt, act_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic [RW-1:0] retry_cnt, retry_n;
    logic          lost_n, tmo_pulse_n;
    logic          active;

    // up&dn together is a reset overlap in the PFD, not a phase error.
    assign active = up ^ dn;
    assign state  = cur_st;

    // Counters default to zero so every state entry starts from a clean count;
    // each state only carries forward the counters it actually uses.
    always_comb begin
        nxt_st      = cur_st;
        flush_n     = '0;
        quiet_n     = '0;
        act_n       = '0;
        tmo_n       = '0;
        retry_n     = retry_cnt;
        lost_n      = 1'b0;
        tmo_pulse_n = 1'b0;

        if (!enable && cur_st != S_IDLE) begin
            nxt_st  = S_IDLE;
            retry_n = '0;
        end else begin
            case (cur_st)
                S_IDLE: begin
                    if (enable) nxt_st = S_FLUSH;
                end
                S_FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) nxt_st = S_ACQ;
                    else                          flush_n = flush_cnt + FW'(1);
                end
                S_ACQ: begin
                    if (!active)
                        quiet_n = (quiet_cnt == LOCK_TH) ? quiet_cnt : quiet_cnt + QW'(1);
                    tmo_n = (tmo_cnt == TMO_TH) ? tmo_cnt : tmo_cnt + TW'(1);
                    // Lock is checked first so a simultaneous timeout is ignored.
                    if (quiet_n == LOCK_TH) begin
                        nxt_st  = S_LOCK;
                        retry_n = '0;
                        quiet_n = '0;
                        tmo_n   = '0;
                    end else if (tmo_n == TMO_TH) begin
                        tmo_pulse_n = 1'b1;
                        retry_n     = (retry_cnt == RETRY_TH) ? retry_cnt : retry_cnt + RW'(1);
                        nxt_st      = (retry_n == RETRY_TH) ? S_FAIL : S_FLUSH;
                        quiet_n     = '0;
                        tmo_n       = '0;
                    end
                end
                S_LOCK: begin
                    if (active)
                        act_n = (act_cnt == UNLOCK_TH) ? act_cnt : act_cnt + AW'(1);
                    if (act_n == UNLOCK_TH) begin
                        nxt_st = S_FLUSH;
                        lost_n = 1'b1;
                        act_n  = '0;
                    end
                end
                S_FAIL: begin
                    nxt_st = S_FAIL;
                end
                default: begin
                    nxt_st = S_IDLE;
                end
            endcase
        end
    end

    // Level outputs are decoded from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_st      <= S_IDLE;
            flush_cnt   <= '0;
            quiet_cnt   <= '0;
            act_cnt     <= '0;
            tmo_cnt     <= '0;
            retry_cnt   <= '0;
            lf_rst      <= 1'b1;
            gain_coarse <= 1'b1;
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
            acq_tmo     <= 1'b0;
            fail        <= 1'b0;
        end else begin
            cur_st      <= nxt_st;
            flush_cnt   <= flush_n;
            quiet_cnt   <= quiet_n;
            act_cnt     <= act_n;
            tmo_cnt     <= tmo_n;
            retry_cnt   <= retry_n;
            lf_rst      <= (nxt_st == S_IDLE) || (nxt_st == S_FLUSH) || (nxt_st == S_FAIL);
            gain_coarse <= (nxt_st != S_LOCK);
            locked      <= (nxt_st == S_LOCK);
            lock_lost   <= lost_n;
            acq_tmo     <= tmo_pulse_n;
            fail        <= (nxt_st == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_acq_ctrl.sv
// Directed bench for pll_acq_ctrl. Observed outputs are packed as
// {state[2:0], lf_rst, gain_coarse, locked, lock_lost, acq_tmo, fail}.
module tb_pll_acq_ctrl;

    logic       clk = 1'b0;
    logic       rst, enable, up, dn;
    logic       lf_rst, gain_coarse, locked, lock_lost, acq_tmo, fail;
    logic [2:0] state;

    logic       rst2, enable2, up2, dn2;
    logic       lf_rst2, gain_coarse2, locked2, lock_lost2, acq_tmo2, fail2;
    logic [2:0] state2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pll_acq_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .up(up), .dn(dn),
        .lf_rst(lf_rst), .gain_coarse(gain_coarse), .locked(locked),
        .lock_lost(lock_lost), .acq_tmo(acq_tmo), .fail(fail), .state(state)
    );

    // Lock and timeout thresholds equal, to exercise the tie.
    pll_acq_ctrl #(.LOCK_CNT(16), .ACQ_TMO(16)) dut2 (
        .clk(clk), .rst(rst2), .enable(enable2), .up(up2), .dn(dn2),
        .lf_rst(lf_rst2), .gain_coarse(gain_coarse2), .locked(locked2),
        .lock_lost(lock_lost2), .acq_tmo(acq_tmo2), .fail(fail2), .state(state2)
    );

    // Expected-vector shorthands: state + lf_rst/coarse/locked/lost/tmo/fail
    localparam logic [8:0] E_IDLE  = {3'd0, 6'b110000};
    localparam logic [8:0] E_FLUSH = {3'd1, 6'b110000};
    localparam logic [8:0] E_ACQ   = {3'd2, 6'b010000};
    localparam logic [8:0] E_LOCK  = {3'd3, 6'b001000};
    localparam logic [8:0] E_LOST  = {3'd1, 6'b110100};
    localparam logic [8:0] E_TMO   = {3'd1, 6'b110010};
    localparam logic [8:0] E_FAILT = {3'd4, 6'b110011};
    localparam logic [8:0] E_FAIL  = {3'd4, 6'b110001};

    function automatic logic [8:0] obs1();
        return {state, lf_rst, gain_coarse, locked, lock_lost, acq_tmo, fail};
    endfunction

    function automatic logic [8:0] obs2();
        return {state2, lf_rst2, gain_coarse2, locked2, lock_lost2, acq_tmo2, fail2};
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive alternating PFD activity so quiet_cnt never exceeds 1.
    task automatic run_alt(input int n);
        for (int i = 0; i < n; i++) begin
            up = ~up;
            tick(1);
        end
        up = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; up = 1'b0; dn = 1'b0;
        rst2 = 1'b1; enable2 = 1'b1; up2 = 1'b0; dn2 = 1'b0;

        // 1: reset, flush, lock after 16 quiet cycles
        tick(3);
        chk("reset", obs1(), E_IDLE);
        rst = 1'b0;
        tick(1);  chk("flush_entry", obs1(), E_FLUSH);
        tick(3);  chk("flush_last", obs1(), E_FLUSH);
        tick(1);  chk("acq_entry", obs1(), E_ACQ);
        tick(15); chk("acq_q15", obs1(), E_ACQ);
        tick(1);  chk("lock_q16", obs1(), E_LOCK);

        // 3: 3 active then quiet (up&dn) keeps lock; 4 active loses it
        dn = 1'b1;
        tick(3);  chk("lock_act3", obs1(), E_LOCK);
        up = 1'b1;
        tick(1);  chk("lock_updn_quiet", obs1(), E_LOCK);
        up = 1'b0;
        tick(3);  chk("lock_act3b", obs1(), E_LOCK);
        tick(1);  chk("lock_lost", obs1(), E_LOST);
        dn = 1'b0;
        tick(1);  chk("lost_pulse_end", obs1(), E_FLUSH);
        tick(3);  chk("reacq_entry", obs1(), E_ACQ);

        // 2: a single active cycle restarts the quiet count
        tick(15);
        up = 1'b1;
        tick(1);  chk("acq_break", obs1(), E_ACQ);
        up = 1'b0;
        tick(15); chk("acq_restart15", obs1(), E_ACQ);
        tick(1);  chk("acq_restart_lock", obs1(), E_LOCK);

        // 5a: enable low in LOCK
        enable = 1'b0;
        tick(1);  chk("dis_lock", obs1(), E_IDLE);
        tick(1);  chk("idle_hold", obs1(), E_IDLE);
        enable = 1'b1;
        tick(1);  chk("en_flush", obs1(), E_FLUSH);
        tick(4);  chk("en_acq", obs1(), E_ACQ);

        // 4: three timeouts -> FAIL
        run_alt(1023); chk("tmo1_pre", obs1(), E_ACQ);
        run_alt(1);    chk("tmo1", obs1(), E_TMO);
        tick(1);       chk("tmo1_pulse_end", obs1(), E_FLUSH);
        tick(3);       chk("tmo1_reacq", obs1(), E_ACQ);
        run_alt(1024); chk("tmo2", obs1(), E_TMO);
        tick(4);       chk("tmo2_reacq", obs1(), E_ACQ);
        run_alt(1024); chk("tmo3_fail", obs1(), E_FAILT);
        tick(2);       chk("fail_sticky", obs1(), E_FAIL);

        // 5b: enable low in FAIL, retry count restarts
        enable = 1'b0;
        tick(1);  chk("dis_fail", obs1(), E_IDLE);
        enable = 1'b1;
        tick(1);  chk("refl", obs1(), E_FLUSH);
        tick(4);  chk("re_acq", obs1(), E_ACQ);
        run_alt(1024); chk("retry_cleared", obs1(), E_TMO);

        // mid-operation reset
        rst = 1'b1;
        tick(1);  chk("rst_mid", obs1(), E_IDLE);
        rst = 1'b0;

        // 6: lock and timeout on the same cycle, then reset in LOCK
        rst2 = 1'b0;
        tick(1);  chk("d2_flush", obs2(), E_FLUSH);
        tick(4);  chk("d2_acq", obs2(), E_ACQ);
        tick(15); chk("d2_acq15", obs2(), E_ACQ);
        tick(1);  chk("d2_tie_lock", obs2(), E_LOCK);
        tick(2);  chk("d2_lock_hold", obs2(), E_LOCK);
        rst2 = 1'b1;
        tick(1);  chk("d2_rst_lock", obs2(), E_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
